// File: rtl/cv_ctrl_pkg.sv
// Shared constants and types for the ColecoVision controller port block:
// key codes, button bit positions and the keypad/joystick pin bundle.
package cv_ctrl_pkg;

  localparam int BTN_W      = 20;
  localparam int BTN_STAR   = 10;
  localparam int BTN_HASH   = 11;
  localparam int BTN_PURPLE = 12;
  localparam int BTN_BLUE   = 13;
  localparam int BTN_UP     = 14;
  localparam int BTN_DOWN   = 15;
  localparam int BTN_LEFT   = 16;
  localparam int BTN_RIGHT  = 17;
  localparam int BTN_FIRE   = 18;
  localparam int BTN_ARM    = 19;

  // Keypad codes as {p1,p2,p3,p4}, active-low
  localparam logic [3:0] KC_0      = 4'b0011;
  localparam logic [3:0] KC_1      = 4'b1110;
  localparam logic [3:0] KC_2      = 4'b1101;
  localparam logic [3:0] KC_3      = 4'b0110;
  localparam logic [3:0] KC_4      = 4'b0001;
  localparam logic [3:0] KC_5      = 4'b1001;
  localparam logic [3:0] KC_6      = 4'b0111;
  localparam logic [3:0] KC_7      = 4'b1100;
  localparam logic [3:0] KC_8      = 4'b1000;
  localparam logic [3:0] KC_9      = 4'b1011;
  localparam logic [3:0] KC_STAR   = 4'b1010;
  localparam logic [3:0] KC_HASH   = 4'b0101;
  localparam logic [3:0] KC_PURPLE = 4'b0100;
  localparam logic [3:0] KC_BLUE   = 4'b0010;
  localparam logic [3:0] KC_NONE   = 4'b1111;

  typedef struct packed {
    logic p1;
    logic p2;
    logic p3;
    logic p4;
    logic p6;
  } cv_pins_t;

  function automatic logic [3:0] kp_code(input int idx);
    case (idx)
      0:          return KC_0;
      1:          return KC_1;
      2:          return KC_2;
      3:          return KC_3;
      4:          return KC_4;
      5:          return KC_5;
      6:          return KC_6;
      7:          return KC_7;
      8:          return KC_8;
      9:          return KC_9;
      BTN_STAR:   return KC_STAR;
      BTN_HASH:   return KC_HASH;
      BTN_PURPLE: return KC_PURPLE;
      BTN_BLUE:   return KC_BLUE;
      default:    return KC_NONE;
    endcase
  endfunction

  // Walk downward so the lowest pressed index is the last to write
  function automatic logic [3:0] kp_encode(input logic [13:0] keys);
    logic [3:0] c;
    c = KC_NONE;
    for (int b = 13; b >= 0; b--)
      if (keys[b]) c = kp_code(b);
    return c;
  endfunction

  // Quadrature phase index to {p7,p9}: 11 -> 01 -> 00 -> 10
  function automatic logic [1:0] cv_quad_pins(input logic [1:0] q);
    case (q)
      2'd0:    return 2'b11;
      2'd1:    return 2'b01;
      2'd2:    return 2'b00;
      default: return 2'b10;
    endcase
  endfunction

endpackage

// File: rtl/cv_ctrl_ports_if.sv
// Frontend/console side signals of the controller port block, one lane per port.
interface cv_ctrl_ports_if #(
  parameter int NUM_PORTS = 2,
  parameter int DELTA_W   = 8
);
  logic [NUM_PORTS-1:0][19:0]        keypad_i;
  logic [NUM_PORTS-1:0][DELTA_W-1:0] spin_delta_i;
  logic [NUM_PORTS-1:0]              spin_valid_i;
  logic [NUM_PORTS-1:0]              ctrl_p5_i;
  logic [NUM_PORTS-1:0]              ctrl_p8_i;
  logic [NUM_PORTS-1:0]              ctrl_p1_o;
  logic [NUM_PORTS-1:0]              ctrl_p2_o;
  logic [NUM_PORTS-1:0]              ctrl_p3_o;
  logic [NUM_PORTS-1:0]              ctrl_p4_o;
  logic [NUM_PORTS-1:0]              ctrl_p6_o;
  logic [NUM_PORTS-1:0]              ctrl_p7_o;
  logic [NUM_PORTS-1:0]              ctrl_p9_o;

  modport master (
    output keypad_i, spin_delta_i, spin_valid_i, ctrl_p5_i, ctrl_p8_i,
    input  ctrl_p1_o, ctrl_p2_o, ctrl_p3_o, ctrl_p4_o, ctrl_p6_o, ctrl_p7_o, ctrl_p9_o
  );

  modport slave (
    input  keypad_i, spin_delta_i, spin_valid_i, ctrl_p5_i, ctrl_p8_i,
    output ctrl_p1_o, ctrl_p2_o, ctrl_p3_o, ctrl_p4_o, ctrl_p6_o, ctrl_p7_o, ctrl_p9_o
  );
endinterface

// File: rtl/cv_spinner_quad.sv
// Roller spinner emulation: saturating motion accumulator drained one count
// per divider period into a quadrature phase on {p7,p9}.
module cv_spinner_quad
  import cv_ctrl_pkg::*;
#(
  parameter int DELTA_W  = 8,
  parameter int ACC_W    = 10,
  parameter int SPIN_DIV = 1024
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clk_en_i,
  input  logic               spin_valid_i,
  input  logic [DELTA_W-1:0] spin_delta_i,
  output logic               p7_o,
  output logic               p9_o
);
  localparam int DIV_W = (SPIN_DIV > 1) ? $clog2(SPIN_DIV) : 1;
  localparam int SW    = ACC_W + 2;
  localparam logic signed [SW-1:0] LIM = SW'((2 ** (ACC_W - 1)) - 1);

  logic [DIV_W-1:0]        div_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [1:0]              q_q, q_d;
  logic [1:0]              pins_q;
  logic                    tc, step;
  logic signed [SW-1:0]    sum;

  assign tc   = clk_en_i && (div_q == DIV_W'(SPIN_DIV - 1));
  assign step = tc && (acc_q != '0);

  // Delta and step combine before a single saturation, so excess is dropped
  always_comb begin
    sum = {{2{acc_q[ACC_W-1]}}, acc_q};
    q_d = q_q;
    if (spin_valid_i)
      sum = sum + {{(SW-DELTA_W){spin_delta_i[DELTA_W-1]}}, spin_delta_i};
    if (step) begin
      if (acc_q[ACC_W-1]) begin
        sum = sum + SW'(1);
        q_d = q_q - 2'd1;
      end else begin
        sum = sum - SW'(1);
        q_d = q_q + 2'd1;
      end
    end
    if (sum > LIM)       sum = LIM;
    else if (sum < -LIM) sum = -LIM;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      div_q  <= '0;
      acc_q  <= '0;
      q_q    <= 2'd0;
      pins_q <= 2'b11;
    end else begin
      if (clk_en_i) div_q <= tc ? '0 : div_q + DIV_W'(1);
      acc_q  <= sum[ACC_W-1:0];
      q_q    <= q_d;
      pins_q <= cv_quad_pins(q_d);
    end
  end

  assign p7_o = pins_q[1];
  assign p9_o = pins_q[0];

endmodule

// File: rtl/cv_ctrl_ports.sv
// Multi-port ColecoVision controller interface: registered keypad/joystick
// pin encoding per port plus optional spinner quadrature on p7/p9.
module cv_ctrl_ports
  import cv_ctrl_pkg::*;
#(
  parameter int                   NUM_PORTS = 2,
  parameter int                   DELTA_W   = 8,
  parameter int                   ACC_W     = 10,
  parameter int                   SPIN_DIV  = 1024,
  parameter logic [NUM_PORTS-1:0] SPIN_EN   = '1
) (
  input  logic           clk_i,
  input  logic           reset_n_i,
  input  logic           clk_en_i,
  cv_ctrl_ports_if.slave ctrl
);

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    cv_pins_t kp_h, js_h, pins_q;

    // Each half idles high when deselected so the AND merge lets the other through
    always_comb begin
      kp_h = '1;
      js_h = '1;
      if (!ctrl.ctrl_p5_i[i]) begin
        {kp_h.p1, kp_h.p2, kp_h.p3, kp_h.p4} = kp_encode(ctrl.keypad_i[i][13:0]);
        kp_h.p6 = ~ctrl.keypad_i[i][BTN_ARM];
      end
      if (!ctrl.ctrl_p8_i[i]) begin
        js_h.p1 = ~ctrl.keypad_i[i][BTN_UP];
        js_h.p2 = ~ctrl.keypad_i[i][BTN_DOWN];
        js_h.p3 = ~ctrl.keypad_i[i][BTN_LEFT];
        js_h.p4 = ~ctrl.keypad_i[i][BTN_RIGHT];
        js_h.p6 = ~ctrl.keypad_i[i][BTN_FIRE];
      end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) pins_q <= '1;
      else            pins_q <= cv_pins_t'(kp_h & js_h);
    end

    assign ctrl.ctrl_p1_o[i] = pins_q.p1;
    assign ctrl.ctrl_p2_o[i] = pins_q.p2;
    assign ctrl.ctrl_p3_o[i] = pins_q.p3;
    assign ctrl.ctrl_p4_o[i] = pins_q.p4;
    assign ctrl.ctrl_p6_o[i] = pins_q.p6;

    if (SPIN_EN[i]) begin : g_spin
      cv_spinner_quad #(
        .DELTA_W (DELTA_W),
        .ACC_W   (ACC_W),
        .SPIN_DIV(SPIN_DIV)
      ) u_spin (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .clk_en_i    (clk_en_i),
        .spin_valid_i(ctrl.spin_valid_i[i]),
        .spin_delta_i(ctrl.spin_delta_i[i]),
        .p7_o        (ctrl.ctrl_p7_o[i]),
        .p9_o        (ctrl.ctrl_p9_o[i])
      );
    end else begin : g_nospin
      assign ctrl.ctrl_p7_o[i] = 1'b1;
      assign ctrl.ctrl_p9_o[i] = 1'b1;
    end
  end

endmodule

// File: tb/tb_cv_ctrl_ports.sv
// Directed bench for cv_ctrl_ports: pin encoding checks plus a spinner
// scoreboard fed with expected {p7,p9} phases and drained on every pin change.
module tb_cv_ctrl_ports;
  localparam int NP = 2;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int SD = 4;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  logic clk_en_i = 1'b0;

  cv_ctrl_ports_if #(.NUM_PORTS(NP), .DELTA_W(DW)) cif ();

  cv_ctrl_ports #(
    .NUM_PORTS(NP), .DELTA_W(DW), .ACC_W(AW), .SPIN_DIV(SD), .SPIN_EN(2'b01)
  ) dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clk_en_i (clk_en_i),
    .ctrl     (cif)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_ph = 2'b11;
  logic [1:0] prev = 2'b11;
  bit burst_start = 1'b1;
  int last_step = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [4:0] pins(input int p);
    return {cif.ctrl_p1_o[p], cif.ctrl_p2_o[p], cif.ctrl_p3_o[p], cif.ctrl_p4_o[p], cif.ctrl_p6_o[p]};
  endfunction

  function automatic logic [1:0] spin(input int p);
    return {cif.ctrl_p7_o[p], cif.ctrl_p9_o[p]};
  endfunction

  // Successor of a {p7,p9} pair along the quadrature cycle
  function automatic logic [1:0] nxt(input logic [1:0] ph, input bit fwd);
    if (fwd)
      case (ph) 2'b11: return 2'b01; 2'b01: return 2'b00; 2'b00: return 2'b10; default: return 2'b11; endcase
    else
      case (ph) 2'b11: return 2'b10; 2'b10: return 2'b00; 2'b00: return 2'b01; default: return 2'b11; endcase
  endfunction

  task automatic push_steps(input int n, input bit fwd);
    burst_start = 1'b1;
    for (int k = 0; k < n; k++) begin
      exp_ph = nxt(exp_ph, fwd);
      exp_q.push_back(exp_ph);
    end
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic send_delta(input logic [DW-1:0] d);
    cif.spin_delta_i[0] = d;
    cif.spin_valid_i[0] = 1'b1;
    step();
    cif.spin_valid_i[0] = 1'b0;
    cif.spin_delta_i[0] = '0;
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin step(); t++; end
    chk("spin_drain_pending", exp_q.size(), 0);
    repeat (4 * SD) step();
  endtask

  // Scoreboard drain: every change on port 0 {p7,p9} must match the next queued phase
  always @(negedge clk_i) begin
    if (!reset_n_i) prev = 2'b11;
    else if (spin(0) != prev) begin
      chk("spin_one_bit", $countones(spin(0) ^ prev), 1);
      if (exp_q.size() == 0) chk("spin_unexpected_step", spin(0), prev);
      else chk("spin_phase", spin(0), exp_q.pop_front());
      if (!burst_start) chk("spin_interval", cyc - last_step, SD);
      burst_start = 1'b0;
      last_step = cyc;
      prev = spin(0);
    end
  end

  initial begin
    cif.keypad_i = '0;
    cif.spin_delta_i = '0;
    cif.spin_valid_i = '0;
    cif.ctrl_p5_i = '1;
    cif.ctrl_p8_i = '1;

    repeat (3) step();
    chk("rst_pins_p0", pins(0), 5'h1f);
    chk("rst_pins_p1", pins(1), 5'h1f);
    chk("rst_spin_p0", spin(0), 2'b11);
    reset_n_i = 1'b1;
    step(); step();
    chk("idle_pins_p0", pins(0), 5'h1f);
    chk("idle_pins_p1", pins(1), 5'h1f);
    chk("idle_spin_p1", spin(1), 2'b11);

    // Keypad, port 0
    cif.ctrl_p5_i[0] = 1'b0;
    cif.keypad_i[0][3] = 1'b1;
    cif.keypad_i[0][7] = 1'b1;
    chk("kp_latency", pins(0), 5'b11111);
    step();
    chk("kp_3_over_7", pins(0), 5'b01101);
    cif.keypad_i[0][19] = 1'b1;
    step();
    chk("kp_arm", pins(0), 5'b01100);
    cif.keypad_i[0] = '0;
    cif.keypad_i[0][12] = 1'b1;
    cif.keypad_i[0][13] = 1'b1;
    step();
    chk("kp_purple_over_blue", pins(0), 5'b01001);
    cif.keypad_i[0] = '0;
    cif.keypad_i[0][0] = 1'b1;
    cif.keypad_i[0][11] = 1'b1;
    step();
    chk("kp_0_over_hash", pins(0), 5'b00111);
    cif.keypad_i[0] = '0;
    cif.keypad_i[0][10] = 1'b1;
    step();
    chk("kp_star", pins(0), 5'b10101);
    cif.keypad_i[0] = '0;
    step();
    chk("kp_none", pins(0), 5'b11111);
    cif.keypad_i[0][19] = 1'b1;
    cif.keypad_i[0][4] = 1'b1;
    cif.ctrl_p5_i[0] = 1'b1;
    step();
    chk("kp_deselected", pins(0), 5'b11111);

    // Joystick and merge, port 1
    cif.ctrl_p8_i[1] = 1'b0;
    cif.keypad_i[1][14] = 1'b1;
    cif.keypad_i[1][18] = 1'b1;
    step();
    chk("js_up_fire", pins(1), 5'b01110);
    chk("js_p0_untouched", pins(0), 5'b11111);
    cif.ctrl_p5_i[1] = 1'b0;
    cif.keypad_i[1][5] = 1'b1;
    step();
    chk("merge_5_up", pins(1), 5'b00010);
    cif.keypad_i[1] = '0;
    cif.keypad_i[1][17] = 1'b1;
    cif.keypad_i[1][19] = 1'b1;
    cif.ctrl_p5_i[1] = 1'b1;
    step();
    chk("js_right_nofire", pins(1), 5'b11101);
    cif.ctrl_p8_i[1] = 1'b1;
    step();
    chk("js_deselected", pins(1), 5'b11111);

    // Spinner: +3 then -2
    clk_en_i = 1'b1;
    push_steps(3, 1'b1);
    send_delta(8'sd3);
    wait_idle(10 * SD);
    chk("spin_after_pos3", spin(0), 2'b10);
    push_steps(2, 1'b0);
    send_delta(-8'sd2);
    wait_idle(10 * SD);
    chk("spin_after_neg2", spin(0), 2'b01);

    // Saturation: load with pacing stopped, 5*127 clips at 511, minus 127 leaves 384
    clk_en_i = 1'b0;
    repeat (5) send_delta(8'sd127);
    send_delta(-8'sd127);
    push_steps(384, 1'b1);
    clk_en_i = 1'b1;
    wait_idle(384 * SD + 20 * SD);
    chk("spin_after_sat", spin(0), exp_ph);

    // Reset mid-sequence with acc at 5
    cif.ctrl_p5_i[0] = 1'b0;
    cif.keypad_i[0] = '0;
    cif.keypad_i[0][0] = 1'b1;
    push_steps(8, 1'b1);
    send_delta(8'sd8);
    begin
      int t = 0;
      while (exp_q.size() != 5 && t < 20 * SD) begin
        @(posedge clk_i); #2; t++;
      end
      chk("spin_reach_acc5", exp_q.size(), 5);
    end
    chk("pre_rst_kp", pins(0), 5'b00111);
    reset_n_i = 1'b0;
    #1;
    chk("async_rst_pins", pins(0), 5'h1f);
    chk("async_rst_spin", spin(0), 2'b11);
    exp_q.delete();
    exp_ph = 2'b11;
    repeat (3) step();
    chk("hold_rst_pins", pins(0), 5'h1f);
    @(posedge clk_i); #2;
    reset_n_i = 1'b1;
    #1;
    chk("post_rel_pins", pins(0), 5'h1f);
    step();
    chk("first_edge_kp", pins(0), 5'b00111);
    repeat (8 * SD) step();
    chk("no_steps_after_rst", spin(0), 2'b11);
    chk("spin_disabled_p1", spin(1), 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
